// File: rtl/lap_pkg.sv
// Shared types and constants for the lap-time stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lap_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // BCD time constants: zero lap and the largest two-digit reading.
    localparam logic [2*BCD_W-1:0] BCD_ZERO = 8'h00;
    localparam logic [2*BCD_W-1:0] BCD_MAX  = 8'h99;

    // Lap computation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUB_ONES = 2'd1,
        ST_SUB_TENS = 2'd2,
        ST_COMMIT   = 2'd3
    } lap_state_t;

    // True when a nibble holds a legal decimal digit.
    function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract a - b - borrow_in, result folded back into 0-9.
// Latency: purely combinational.
// Backpressure: none; operands are consumed in the cycle they are presented.
module bcd_digit_sub
    import lap_pkg::*;
(
    input  logic [BCD_W-1:0] a_i,
    input  logic [BCD_W-1:0] b_i,
    input  logic             borrow_i,
    output logic [BCD_W-1:0] diff_o,
    output logic             borrow_o
);

    logic [BCD_W:0] raw;

    // Subtract with one extra bit; a set top bit means the result went negative
    // and the digit is corrected by adding ten (low nibble wraps modulo 16).
    always_comb begin
        raw      = {1'b0, a_i} - {1'b0, b_i} - {{BCD_W{1'b0}}, borrow_i};
        borrow_o = raw[BCD_W];
        diff_o   = raw[BCD_W] ? (raw[BCD_W-1:0] + 4'd10) : raw[BCD_W-1:0];
    end

endmodule

// File: rtl/lap_tracker.sv
// Lap timer: on a strobe, lap = now - previous mark (mod 100, BCD); tracks best lap and lap count.
// Latency: strobe in cycle N -> lap_valid in cycle N+3; busy high in N+1..N+3.
// Backpressure: strobes arriving while busy are dropped, never queued.
module lap_tracker
    import lap_pkg::*;
#(
    parameter int MAX_LAPS  = 15,
    parameter int LAP_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [7:0]           time_bcd,
    input  logic                 lap_strobe,
    output logic                 busy,
    output logic                 lap_valid,
    output logic [7:0]           lap_bcd,
    output logic [7:0]           best_bcd,
    output logic                 best_valid,
    output logic                 new_best,
    output logic [LAP_CNT_W-1:0] lap_count,
    output logic                 bcd_err
);

    localparam logic [LAP_CNT_W-1:0] CNT_MAX = LAP_CNT_W'(MAX_LAPS);

    lap_state_t state_q, state_d;

    logic [7:0]           cur_q;
    logic [7:0]           mark_q;
    logic [BCD_W-1:0]     d0_q;
    logic                 borrow_q;
    logic [7:0]           lap_q;
    logic [7:0]           best_q;
    logic                 best_valid_q;
    logic                 new_best_q;
    logic                 lap_valid_q;
    logic [LAP_CNT_W-1:0] cnt_q;
    logic                 err_q;

    logic                 clear;
    logic                 time_ok;
    logic                 accept;
    logic                 reject;
    logic                 do_ones;
    logic                 do_tens;
    logic [BCD_W-1:0]     sub_a;
    logic [BCD_W-1:0]     sub_b;
    logic                 sub_bin;
    logic [BCD_W-1:0]     sub_diff;
    logic                 sub_bout;
    logic [7:0]           lap_new;
    logic                 is_better;

    assign clear   = reset | init;
    assign time_ok = bcd_digit_ok(time_bcd[7:4]) & bcd_digit_ok(time_bcd[3:0]);

    // State register; reset and init both force the sequencer back to idle.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a legal strobe in idle starts the ones/tens/commit sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (lap_strobe && time_ok) state_d = ST_SUB_ONES;
            ST_SUB_ONES: state_d = ST_SUB_TENS;
            ST_SUB_TENS: state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls and the operand mux feeding the shared digit subtractor.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        accept  = (state_q == ST_IDLE) && lap_strobe && time_ok;
        reject  = (state_q == ST_IDLE) && lap_strobe && !time_ok;
        do_ones = (state_q == ST_SUB_ONES);
        do_tens = (state_q == ST_SUB_TENS);
        sub_a   = do_tens ? cur_q[7:4]  : cur_q[3:0];
        sub_b   = do_tens ? mark_q[7:4] : mark_q[3:0];
        sub_bin = do_tens ? borrow_q    : 1'b0;
    end

    bcd_digit_sub u_sub (
        .a_i      (sub_a),
        .b_i      (sub_b),
        .borrow_i (sub_bin),
        .diff_o   (sub_diff),
        .borrow_o (sub_bout)
    );

    // Lap result is the tens digit coming out of the subtractor now plus the stored ones digit.
    // Better-lap test compares tens first, then ones; zero laps never qualify.
    always_comb begin
        lap_new   = {sub_diff, d0_q};
        is_better = (lap_new != BCD_ZERO) &&
                    ((lap_new[7:4] < best_q[7:4]) ||
                     ((lap_new[7:4] == best_q[7:4]) && (lap_new[3:0] < best_q[3:0])));
    end

    // Datapath: capture, per-digit subtract, and results registered on entry to commit
    // so the outputs and the valid pulse are visible together during the commit cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            cur_q        <= BCD_ZERO;
            mark_q       <= BCD_ZERO;
            d0_q         <= '0;
            borrow_q     <= 1'b0;
            lap_q        <= BCD_ZERO;
            best_q       <= BCD_MAX;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
            lap_valid_q  <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            lap_valid_q <= 1'b0;
            new_best_q  <= 1'b0;
            if (accept) begin
                cur_q <= time_bcd;
            end
            if (reject) begin
                err_q <= 1'b1;
            end
            if (do_ones) begin
                d0_q     <= sub_diff;
                borrow_q <= sub_bout;
            end
            if (do_tens) begin
                lap_q       <= lap_new;
                mark_q      <= cur_q;
                lap_valid_q <= 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (is_better) begin
                    best_q       <= lap_new;
                    best_valid_q <= 1'b1;
                    new_best_q   <= 1'b1;
                end
            end
        end
    end

    assign lap_valid  = lap_valid_q;
    assign lap_bcd    = lap_q;
    assign best_bcd   = best_q;
    assign best_valid = best_valid_q;
    assign new_best   = new_best_q;
    assign lap_count  = cnt_q;
    assign bcd_err    = err_q;

endmodule

// File: tb/tb_lap_tracker.sv
// Directed scoreboard bench for lap_tracker.
// Expected laps are queued at strobe time; a negedge monitor checks each lap_valid pulse.
// Bounded waits everywhere; summary line at the end.
module tb_lap_tracker;

    logic       clk = 1'b0;
    logic       reset, init, lap_strobe;
    logic [7:0] time_bcd;
    logic       busy, lap_valid, best_valid, new_best, bcd_err;
    logic [7:0] lap_bcd, best_bcd;
    logic [3:0] lap_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int pushes = 0;

    typedef struct {
        logic [7:0] lap;
        logic [7:0] best;
        logic       bv;
        logic       nb;
        logic [3:0] cnt;
        int         at;
    } exp_t;

    exp_t sbq[$];

    lap_tracker #(.MAX_LAPS(15), .LAP_CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .time_bcd   (time_bcd),
        .lap_strobe (lap_strobe),
        .busy       (busy),
        .lap_valid  (lap_valid),
        .lap_bcd    (lap_bcd),
        .best_bcd   (best_bcd),
        .best_valid (best_valid),
        .new_best   (new_best),
        .lap_count  (lap_count),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare on every lap_valid pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (new_best && !lap_valid) chk("new_best_without_valid", 1, 0);
            if (lap_valid) begin
                exp_t e;
                pulses++;
                if (sbq.size() == 0) begin
                    chk("unexpected_lap_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("lap_latency", cyc, e.at);
                    chk("lap_bcd",     lap_bcd, e.lap);
                    chk("best_bcd",    best_bcd, e.best);
                    chk("best_valid",  best_valid, e.bv);
                    chk("new_best",    new_best, e.nb);
                    chk("lap_count",   lap_count, e.cnt);
                end
            end
        end
    end

    task automatic push(input logic [7:0] lap, input logic [7:0] best, input logic bv,
                        input logic nb, input logic [3:0] cnt, input int at);
        exp_t e;
        e.lap = lap; e.best = best; e.bv = bv; e.nb = nb; e.cnt = cnt; e.at = at;
        sbq.push_back(e);
        pushes++;
    endtask

    // One-cycle strobe; returns one cycle later with the strobe low. Outputs strobe cycle.
    task automatic strobe(input logic [7:0] t, output int k);
        @(posedge clk); #1;
        k = cyc;
        time_bcd   = t;
        lap_strobe = 1'b1;
        @(posedge clk); #1;
        lap_strobe = 1'b0;
    endtask

    task automatic lap(input logic [7:0] t, input logic [7:0] l, input logic [7:0] b,
                       input logic nb, input logic [3:0] cnt);
        int k;
        strobe(t, k);
        push(l, b, 1'b1, nb, cnt, k + 3);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_lap_valid"},  lap_valid, 0);
        chk({tag, "_new_best"},   new_best, 0);
        chk({tag, "_lap_bcd"},    lap_bcd, 8'h00);
        chk({tag, "_best_bcd"},   best_bcd, 8'h99);
        chk({tag, "_best_valid"}, best_valid, 0);
        chk({tag, "_lap_count"},  lap_count, 0);
        chk({tag, "_bcd_err"},    bcd_err, 0);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        int k;
        reset = 1'b1; init = 1'b0; lap_strobe = 1'b0; time_bcd = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state("reset");

        // 1: first lap from mark 00
        lap(8'h12, 8'h12, 8'h12, 1'b1, 4'd1);
        wait_idle();

        // 2: slower lap then faster lap
        lap(8'h30, 8'h18, 8'h12, 1'b0, 4'd2);
        wait_idle();
        lap(8'h41, 8'h11, 8'h11, 1'b1, 4'd3);
        wait_idle();

        // 3: move mark to 97, then wrap to 03 -> 06
        lap(8'h97, 8'h56, 8'h11, 1'b0, 4'd4);
        wait_idle();
        lap(8'h03, 8'h06, 8'h06, 1'b1, 4'd5);
        wait_idle();

        // 4: strobe held a second cycle while busy, then zero lap
        @(posedge clk); #1;
        k = cyc;
        time_bcd = 8'h25; lap_strobe = 1'b1;
        push(8'h22, 8'h06, 1'b1, 1'b0, 4'd6, k + 3);
        @(posedge clk); #1;
        chk("busy_after_strobe", busy, 1);
        @(posedge clk); #1;
        lap_strobe = 1'b0;
        wait_idle();
        lap(8'h25, 8'h00, 8'h06, 1'b0, 4'd7);
        wait_idle();
        repeat (3) @(posedge clk);
        #1 chk("lap_pulse_total", pulses, pushes);

        // 5: init aborts a lap in flight; strobe alongside init is discarded
        @(posedge clk); #1;
        time_bcd = 8'h50; lap_strobe = 1'b1;
        @(posedge clk); #1;
        lap_strobe = 1'b0; init = 1'b1;
        @(posedge clk); #1;
        time_bcd = 8'h44; lap_strobe = 1'b1;
        @(posedge clk); #1;
        init = 1'b0; lap_strobe = 1'b0;
        chk("busy_strobe_with_init", busy, 0);
        repeat (4) @(posedge clk);
        #1 check_reset_state("init");

        // 6: illegal digit sets sticky error and is dropped
        strobe(8'h3A, k);
        chk("bcd_err_set", bcd_err, 1);
        chk("busy_after_bad", busy, 0);
        repeat (4) @(posedge clk);
        #1 chk("count_after_bad", lap_count, 0);

        // 16 legal laps of 5 s each from mark 00; count saturates at 15
        for (int i = 0; i < 16; i++) begin
            lap(to_bcd((i + 1) * 5), 8'h05, 8'h05, (i == 0), (i < 15) ? 4'(i + 1) : 4'd15);
            wait_idle();
        end
        repeat (4) @(posedge clk);
        #1;
        chk("count_saturated", lap_count, 15);
        chk("bcd_err_sticky", bcd_err, 1);
        chk("scoreboard_drained", sbq.size(), 0);
        chk("lap_pulse_total_end", pulses, pushes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
